ha_serial_adder_ctrl: RTL
=========================

# ha_serial_adder_ctrl

Sequencer that time-shares a single half-adder cell to perform WIDTH-bit binary addition, one bit at a time. Each bit takes two passes through the cell: first operand bits, then partial sum with running carry. The block sits between the top-level TinyTapeout wrapper's I/O pins and the half-adder datapath. A start/busy/done handshake lets the wrapper or an external host launch additions and collect results.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..16
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; latched on accepted start
- b  in  WIDTH  operand B; latched on accepted start
- cin  in  1  carry-in; latched on accepted start
- busy  out  1  high while a computation is in progress (PASS1/PASS2)
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  result; held until next accepted start
- cout  out  1  carry-out; held with sum

## Operation
- States: IDLE, PASS1, PASS2, DONE; bit index i counts 0..WIDTH-1.
- IDLE, start=1: latch a, b → op regs; carry ← cin; i ← 0; clear sum and cout; go PASS1.
- PASS1: cell inputs (a[i], b[i]); register s1 ← S, c1 ← C; go PASS2.
- PASS2: cell inputs (s1, carry); sum[i] ← S; carry ← c1 | C.
  - If i = WIDTH-1, go DONE; else i ← i+1 and go PASS1.
- DONE: done=1 for this one cycle; cout ← carry (visible from this cycle); go IDLE.
- c1 and C are never both 1. The OR is the only logic outside the cell.
- start while not IDLE (including DONE) is ignored. Operand changes after acceptance have no effect.
- Result is modulo 2^WIDTH; the overflow bit is cout.
- WIDTH=1: a single PASS1/PASS2 pair, then DONE.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, i=0, carry=0.
- Start accepted at edge k gives the following:
  - busy=1 from cycle k+1 through k+2·WIDTH.
  - done=1 in cycle k+2·WIDTH+1, with busy=0 in that cycle.
- Latency from start to done is 2·WIDTH+1 cycles; for WIDTH=8 this is 17.
- Minimum start-to-start spacing is 2·WIDTH+2 cycles.
- sum bits update progressively during busy and are final only when done=1. Consumers sample on done.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values. No done is issued. The partial result is discarded.
- rst and start in the same cycle: rst wins and start is dropped.

## Structure
- Shared package ha_pkg holds the following:
  - the state enum (IDLE, PASS1, PASS2, DONE);
  - the default WIDTH constant;
  - the index width function clog2(WIDTH), with minimum 1.
- Sub-module half_adder_cell: combinational; inputs x, y; outputs S = x^y, C = x&y. Exactly one instance.
- Cell input muxing is selected by state.
- The top-level wrapper maps ui_in/uio_in to a, b, cin, start and uo_out to sum, with cout/done/busy on uio_out.

## Test plan
- Reset, then 8'h0F + 8'h01, cin=0 → sum=8'h10, cout=0; done exactly 17 cycles after start edge; busy high 16 cycles.
- 8'hFF + 8'h01, cin=0 → sum=8'h00, cout=1; 8'hFF + 8'hFF, cin=1 → sum=8'hFF, cout=1.
- start re-asserted at cycles +3 and +17 (DONE) with different operands → ignored; original result delivered; sum/cout held afterward.
- rst pulsed at cycle +9 of a 8'hAA + 8'h55 run → busy=0, sum=0, cout=0 next cycle; no done pulse; new start then gives sum=8'hFF, cout=0.
- Operands changed every cycle while busy → result matches values latched at start; back-to-back starts at 18-cycle spacing all complete.
- WIDTH=1, exhaustive a, b, cin over 8 combinations → correct {cout, sum}; done 3 cycles after start.

Source files
------------

// File: rtl/ha_pkg.sv
// Shared types and constants for the serial half-adder sequencer.
package ha_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit-index width; at least one bit so WIDTH=1 still has a legal counter.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 1) ? int'($clog2(w)) : 1;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single combinational half-adder cell shared by both passes of every bit.
module half_adder_cell (
    input  logic x,
    input  logic y,
    output logic s_c,
    output logic c_c
);

    assign s_c = x ^ y;
    assign c_c = x & y;

endmodule

// File: rtl/ha_serial_adder_ctrl.sv
// Bit-serial adder sequencer: two passes per bit through one half-adder cell,
// with a start/busy/done handshake and held sum/cout.
module ha_serial_adder_ctrl
    import ha_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned IW = idx_w(WIDTH);

    state_e           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] a_op_q, a_op_d;
    logic [WIDTH-1:0] b_op_q, b_op_d;
    logic             carry_q, carry_d;
    logic             s1_q, s1_d;
    logic             c1_q, c1_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic a_bit, b_bit;
    logic cell_x, cell_y, cell_s, cell_c;
    logic last_bit;

    // Current operand bits, selected by the running bit index.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (i_q == IW'(k)) begin
                a_bit = a_op_q[k];
                b_bit = b_op_q[k];
            end
        end
    end

    assign last_bit = (i_q == IW'(WIDTH - 1));

    // PASS2 reuses the cell for partial sum plus running carry.
    always_comb begin
        cell_x = a_bit;
        cell_y = b_bit;
        if (state_q == ST_PASS2) begin
            cell_x = s1_q;
            cell_y = carry_q;
        end
    end

    half_adder_cell u_cell (
        .x   (cell_x),
        .y   (cell_y),
        .s_c (cell_s),
        .c_c (cell_c)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        a_op_d  = a_op_q;
        b_op_d  = b_op_q;
        carry_d = carry_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_op_d  = a;
                    b_op_d  = b;
                    carry_d = cin;
                    i_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ST_PASS1;
                end
            end
            ST_PASS1: begin
                s1_d    = cell_s;
                c1_d    = cell_c;
                state_d = ST_PASS2;
            end
            ST_PASS2: begin
                for (int unsigned k = 0; k < WIDTH; k++) begin
                    if (i_q == IW'(k)) begin
                        sum_d[k] = cell_s;
                    end
                end
                // c1 and the second-pass carry are mutually exclusive, so OR suffices.
                carry_d = c1_q | cell_c;
                if (last_bit) begin
                    cout_d  = c1_q | cell_c;
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = ST_PASS1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PASS1) || (state_d == ST_PASS2);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            a_op_q  <= '0;
            b_op_q  <= '0;
            carry_q <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            a_op_q  <= a_op_d;
            b_op_q  <= b_op_d;
            carry_q <= carry_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
